// File: rtl/sort_stream_tx.sv
// Load-then-sort-then-stream engine: bubble sort in place, one compare per cycle, then a ready/valid output stream.
// Define SORT_EARLY_EXIT_EN to end the sort after the first pass that performs no swaps.
module sort_stream_tx #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dato,
  input  logic             cargar,
  output logic             cargar_listo,
  input  logic             ordenar,
  output logic [WIDTH-1:0] salida,
  output logic             salida_valida,
  input  logic             salida_listo,
  output logic             fin,
  output logic             ocupado
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SORT, SEND} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;
  logic [IW-1:0]   rd_q, rd_d;
  logic            swapped_q, swapped_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             load;
  logic             xfer;
  logic             do_swap;
  logic             pass_end;
  logic             last_pass;
  logic [IW-1:0]    j_nxt;
  logic [CW-1:0]    last_j;
  logic [WIDTH-1:0] cmp_a, cmp_b;

  assign load      = (state_q == IDLE) && cargar && (count_q != FULL);
  assign xfer      = (state_q == SEND) && salida_listo;
  assign j_nxt     = j_q + IW'(1);
  assign cmp_a     = mem_q[j_q];
  assign cmp_b     = mem_q[j_nxt];
  assign do_swap   = (state_q == SORT) && (count_q > CW'(1)) && (cmp_a > cmp_b);
  assign last_j    = count_q - CW'(2) - {1'b0, i_q};
  assign pass_end  = ({1'b0, j_q} == last_j);
  assign last_pass = ({1'b0, i_q} == count_q - CW'(2));

  // NOTE: every next-state signal takes its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    i_d       = i_q;
    j_d       = j_q;
    rd_d      = rd_q;
    swapped_d = swapped_q;
    case (state_q)
      IDLE: begin
        if (load) count_d = count_q + CW'(1);
        // A load on the same edge as the start request is included in the sort.
        if (ordenar && (count_q != '0 || load)) begin
          state_d   = SORT;
          i_d       = '0;
          j_d       = '0;
          swapped_d = 1'b0;
        end
      end
      SORT: begin
        if (count_q == CW'(1)) begin
          state_d = SEND;
          rd_d    = '0;
        end else begin
          swapped_d = swapped_q | do_swap;
          if (pass_end) begin
            if (last_pass) begin
              state_d = SEND;
              rd_d    = '0;
            end
`ifdef SORT_EARLY_EXIT_EN
            else if (!(swapped_q || do_swap)) begin
              state_d = SEND;
              rd_d    = '0;
            end
`endif
            else begin
              i_d       = i_q + IW'(1);
              j_d       = '0;
              swapped_d = 1'b0;
            end
          end else begin
            j_d = j_nxt;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if ({1'b0, rd_q} == count_q - CW'(1)) begin
            state_d = IDLE;
            count_d = '0;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      rd_q      <= '0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      i_q       <= i_d;
      j_q       <= j_d;
      rd_q      <= rd_d;
      swapped_q <= swapped_d;
    end
  end

  // NOTE: storage has no reset; count_q = 0 hides stale contents, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load) begin
        mem_q[count_q[IW-1:0]] <= dato;
      end else if (do_swap) begin
        mem_q[j_q]   <= cmp_b;
        mem_q[j_nxt] <= cmp_a;
      end
    end
  end

  assign cargar_listo  = (state_q == IDLE) && (count_q != FULL);
  assign salida_valida = (state_q == SEND);
  assign salida        = (state_q == SEND) ? mem_q[rd_q] : '0;
  assign fin           = (state_q == SEND) && ({1'b0, rd_q} == count_q - CW'(1));
  assign ocupado       = (state_q != IDLE);

endmodule

// File: tb/tb_sort_stream_tx.sv
// Self-checking bench for sort_stream_tx: vector table, hand-written corner sequences and randomized runs vs a sort model.
module tb_sort_stream_tx;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst, cargar, ordenar, salida_listo;
  logic         cargar_listo, salida_valida, fin, ocupado;
  logic [W-1:0] dato, salida;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort_stream_tx #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .dato(dato), .cargar(cargar), .cargar_listo(cargar_listo),
    .ordenar(ordenar), .salida(salida), .salida_valida(salida_valida),
    .salida_listo(salida_listo), .fin(fin), .ocupado(ocupado)
  );

  typedef struct packed {
    int               n;
    logic [0:15][7:0] din;
    logic [0:15][7:0] exp;
    int               cyc_full;
    int               cyc_early;
    logic [31:0]      pat;
  } vec_t;

  vec_t tv [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int full, input int early);
`ifdef SORT_EARLY_EXIT_EN
    return early;
`else
    return full;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; cargar = 1'b0; ordenar = 1'b0; salida_listo = 1'b0; dato = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    check("cargar_listo before load", cargar_listo, 1);
    cargar = 1'b1; dato = v;
    tick();
    cargar = 1'b0;
  endtask

  // Counts cycles spent busy without valid output; cargar is held high to show it is ignored.
  task automatic wait_sort(input int exp_cyc, input string name);
    int cyc = 0;
    cargar = 1'b1; dato = 8'hAA;
    check({name, " cargar_listo in SORT"}, cargar_listo, 0);
    while (ocupado && !salida_valida && cyc < 400) begin
      cyc++;
      tick();
    end
    cargar = 1'b0;
    check({name, " sort cycles"}, cyc, exp_cyc);
    check({name, " valid after sort"}, salida_valida, 1);
  endtask

  task automatic sort_and_time(input int exp_cyc, input string name);
    ordenar = 1'b1;
    tick();
    ordenar = 1'b0;
    wait_sort(exp_cyc, name);
  endtask

  task automatic collect(input logic [0:15][7:0] exp, input int n, input int mode,
                         input logic [31:0] pat, input string name);
    int k = 0;
    int cyc = 0;
    logic r;
    logic [7:0] hold;
    while (k < n && cyc < 300) begin
      if (mode == 1) r = 1'($urandom_range(0, 1));
      else           r = (cyc < 32) ? pat[cyc] : 1'b1;
      cyc++;
      if (r) begin
        check({name, " valid"}, salida_valida, 1);
        check({name, " data"}, salida, exp[k]);
        check({name, " fin"}, fin, (k == n - 1) ? 1 : 0);
        salida_listo = 1'b1;
        tick();
        salida_listo = 1'b0;
        k++;
      end else begin
        hold = salida;
        tick();
        check({name, " stall hold"}, salida, hold);
      end
    end
    if (k < n) check({name, " stream timeout"}, k, n);
    check({name, " ocupado after"}, ocupado, 0);
    check({name, " valid after"}, salida_valida, 0);
    check({name, " fin after"}, fin, 0);
  endtask

  task automatic run_case(input int n, input logic [0:15][7:0] din, input logic [0:15][7:0] exp,
                          input int cyc, input int mode, input logic [31:0] pat, input string name);
    for (int k = 0; k < n; k++) load(din[k]);
    sort_and_time(cyc, name);
    collect(exp, n, mode, pat, name);
  endtask

  // Early-exit cost from inversion structure: data is sorted after P passes, where P is the
  // largest count of bigger elements preceding any element; one clean pass follows if room remains.
  function automatic int model_cycles(input int n, input logic [0:15][7:0] d);
    int p = 0;
    int passes;
    int c = 0;
    if (n == 1) return 1;
    for (int k = 0; k < n; k++) begin
      int l = 0;
      for (int m = 0; m < k; m++) if (d[m] > d[k]) l++;
      if (l > p) p = l;
    end
`ifdef SORT_EARLY_EXIT_EN
    passes = (p + 1 < n - 1) ? p + 1 : n - 1;
`else
    passes = n - 1;
`endif
    for (int q = 0; q < passes; q++) c += n - 1 - q;
    return c;
  endfunction

  initial begin
    logic [0:15][7:0] d, e;
    int q[$];
    int n;

    tv[0] = '{6, {8'd56, 8'd18, 8'd19, 8'd22, 8'd15, 8'd23, 80'd0},
                 {8'd15, 8'd18, 8'd19, 8'd22, 8'd23, 8'd56, 80'd0}, 15, 15, 32'hFFFF_FFFF};
    tv[1] = '{4, {8'd1, 8'd2, 8'd3, 8'd4, 96'd0}, {8'd1, 8'd2, 8'd3, 8'd4, 96'd0}, 6, 3, 32'hFFFF_FFFF};
    tv[2] = '{3, {8'd3, 8'd3, 8'd1, 104'd0}, {8'd1, 8'd3, 8'd3, 104'd0}, 3, 3, 32'h0000_0019};
    tv[3] = '{1, {8'd7, 120'd0}, {8'd7, 120'd0}, 1, 1, 32'hFFFF_FFFF};
    tv[4] = '{5, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 88'd0}, {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 88'd0},
              10, 4, 32'hFFFF_FFFF};
    tv[5] = '{2, {8'd255, 8'd0, 112'd0}, {8'd0, 8'd255, 112'd0}, 1, 1, 32'hFFFF_FFFF};

    do_reset();
    check("reset cargar_listo", cargar_listo, 1);
    check("reset valid", salida_valida, 0);
    check("reset fin", fin, 0);
    check("reset ocupado", ocupado, 0);
    check("reset salida", salida, 0);

    // Start request with nothing loaded is ignored.
    ordenar = 1'b1;
    tick();
    ordenar = 1'b0;
    check("empty ordenar ocupado", ocupado, 0);
    tick();
    check("empty ordenar ocupado later", ocupado, 0);
    check("empty ordenar cargar_listo", cargar_listo, 1);

    for (int t = 0; t < 6; t++)
      run_case(tv[t].n, tv[t].din, tv[t].exp, pick(tv[t].cyc_full, tv[t].cyc_early), 0, tv[t].pat,
               $sformatf("vec%0d", t));

    // Fill to capacity, then try a 17th load.
    for (int v = 15; v >= 0; v--) load(8'(v));
    check("full cargar_listo", cargar_listo, 0);
    cargar = 1'b1; dato = 8'd99;
    tick();
    cargar = 1'b0;
    check("full still not ready", cargar_listo, 0);
    sort_and_time(120, "full");
    for (int k = 0; k < 16; k++) e[k] = 8'(k);
    collect(e, 16, 0, 32'hFFFF_FFFF, "full");

    // Load and start on the same edge.
    check("same edge ready", cargar_listo, 1);
    cargar = 1'b1; ordenar = 1'b1; dato = 8'd11;
    tick();
    cargar = 1'b0; ordenar = 1'b0;
    wait_sort(1, "same_edge");
    e = '0; e[0] = 8'd11;
    collect(e, 1, 0, 32'hFFFF_FFFF, "same_edge");

    // Reset in the middle of SORT.
    load(8'd9); load(8'd4); load(8'd2);
    ordenar = 1'b1;
    tick();
    ordenar = 1'b0;
    check("pre-abort ocupado", ocupado, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ocupado", ocupado, 0);
    check("abort valid", salida_valida, 0);
    check("abort cargar_listo", cargar_listo, 1);
    e = '0; e[0] = 8'd5;
    run_case(1, e, e, 1, 0, 32'hFFFF_FFFF, "after_abort");

    // Reset in the middle of SEND: no further transfers.
    load(8'd40); load(8'd30); load(8'd20);
    sort_and_time(3, "send_abort");
    salida_listo = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("send abort valid", salida_valida, 0);
    tick();
    check("send abort valid later", salida_valida, 0);
    check("send abort ocupado", ocupado, 0);
    salida_listo = 1'b0;

    // Randomized runs against the sort model.
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 16);
      d = '0; e = '0;
      q.delete();
      for (int k = 0; k < n; k++) begin
        d[k] = 8'($urandom_range(0, 255));
        q.push_back(int'(d[k]));
      end
      q.sort();
      for (int k = 0; k < n; k++) e[k] = 8'(q[k]);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        load(d[k]);
      end
      sort_and_time(model_cycles(n, d), $sformatf("rand%0d", it));
      collect(e, n, 1, 32'hFFFF_FFFF, $sformatf("rand%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
